// File: rtl/gcd_rr_arbiter.sv
// Round-robin dispatcher for N GCD units with an in-order result return path.
// A circular tag queue remembers which unit got each dispatch so results leave in dispatch order.
module gcd_rr_arbiter #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int D = 8,
  localparam int U = $clog2(N),
  localparam int C = $clog2(D + 1),
  localparam int A = $clog2(D)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           operands_val,
  input  logic [W-1:0]   operands_bits_A,
  input  logic [W-1:0]   operands_bits_B,
  output logic           operands_rdy,
  output logic [N-1:0]   request_val,
  output logic [W-1:0]   request_operands_bits_A,
  output logic [W-1:0]   request_operands_bits_B,
  input  logic [N-1:0]   request_rdy,
  input  logic [N-1:0]   response_val,
  input  logic [N*W-1:0] response_result_bits_data,
  output logic [N-1:0]   response_rdy,
  output logic           result_val,
  output logic [W-1:0]   result_bits_data,
  input  logic           result_rdy,
  output logic [C-1:0]   inflight_count
);

  logic [U-1:0] r_ptr;
  logic [U-1:0] r_q [D];
  logic [A-1:0] r_wr;
  logic [A-1:0] r_rd;
  logic [C-1:0] r_cnt;

  logic         w_any;
  logic [U-1:0] w_gnt;
  logic [U-1:0] w_head;
  logic         w_nonempty;
  logic         w_not_full;
  logic         w_fire_d;
  logic         w_fire_r;

  // First ready unit scanning from the priority pointer with wrap-around.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_any && request_rdy[(int'(r_ptr) + k) % N]) begin
        w_any = 1'b1;
        w_gnt = U'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_nonempty = (r_cnt != '0);
  assign w_not_full = (r_cnt != C'(D));
  assign w_head     = r_q[r_rd];

  assign operands_rdy            = w_any && w_not_full && !reset;
  assign w_fire_d                = operands_val && operands_rdy;
  assign request_val             = w_fire_d ? (N'(1) << w_gnt) : '0;
  assign request_operands_bits_A = operands_bits_A;
  assign request_operands_bits_B = operands_bits_B;

  // Only the unit holding the oldest outstanding tag may hand back a result.
  assign result_val       = w_nonempty && response_val[w_head] && !reset;
  assign result_bits_data = response_result_bits_data[int'(w_head)*W +: W];
  assign w_fire_r         = result_val && result_rdy;
  assign response_rdy     = w_fire_r ? (N'(1) << w_head) : '0;
  assign inflight_count   = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_fire_d) begin
        r_wr  <= r_wr + A'(1);
        r_ptr <= (w_gnt == U'(N - 1)) ? '0 : w_gnt + U'(1);
      end
      if (w_fire_r) begin
        r_rd <= r_rd + A'(1);
      end
      if (w_fire_d && !w_fire_r) begin
        r_cnt <= r_cnt + C'(1);
      end else if (!w_fire_d && w_fire_r) begin
        r_cnt <= r_cnt - C'(1);
      end
    end
  end

  // Tag storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_fire_d) begin
      r_q[r_wr] <= w_gnt;
    end
  end

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// Directed bench for gcd_rr_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations on grant order, result order and occupancy.
module tb_gcd_rr_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 8;
  localparam int C = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           operands_val;
  logic [W-1:0]   operands_bits_A;
  logic [W-1:0]   operands_bits_B;
  logic           operands_rdy;
  logic [N-1:0]   request_val;
  logic [W-1:0]   request_operands_bits_A;
  logic [W-1:0]   request_operands_bits_B;
  logic [N-1:0]   request_rdy;
  logic [N-1:0]   response_val;
  logic [N*W-1:0] response_result_bits_data;
  logic [N-1:0]   response_rdy;
  logic           result_val;
  logic [W-1:0]   result_bits_data;
  logic           result_rdy;
  logic [C-1:0]   inflight_count;

  gcd_rr_arbiter #(.W(W), .N(N), .D(D)) dut (
    .clk(clk), .reset(reset),
    .operands_val(operands_val), .operands_bits_A(operands_bits_A),
    .operands_bits_B(operands_bits_B), .operands_rdy(operands_rdy),
    .request_val(request_val), .request_operands_bits_A(request_operands_bits_A),
    .request_operands_bits_B(request_operands_bits_B), .request_rdy(request_rdy),
    .response_val(response_val), .response_result_bits_data(response_result_bits_data),
    .response_rdy(response_rdy), .result_val(result_val),
    .result_bits_data(result_bits_data), .result_rdy(result_rdy),
    .inflight_count(inflight_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: tags in dispatch order, priority pointer.
  int mq[$];
  int mP = 0;
  bit m_push = 0, m_pop = 0;
  int m_g = 0;
  int glog[$];
  logic [W-1:0] rlog[$];

  always @(negedge clk) begin
    int g, head;
    bit any, e_ordy, e_resv;
    logic [N-1:0] e_rv, e_rr;
    any = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && request_rdy[(mP + k) % N]) begin any = 1; g = (mP + k) % N; end
    end
    e_ordy = any && (mq.size() < D) && !reset;
    e_rv   = (operands_val && e_ordy) ? N'(1) << g : '0;
    head   = (mq.size() > 0) ? mq[0] : 0;
    e_resv = (mq.size() > 0) && response_val[head] && !reset;
    e_rr   = (e_resv && result_rdy) ? N'(1) << head : '0;
    chk("operands_rdy", operands_rdy, e_ordy);
    chk("request_val", request_val, e_rv);
    chk("result_val", result_val, e_resv);
    chk("response_rdy", response_rdy, e_rr);
    chk("inflight_count", inflight_count, mq.size());
    if (e_resv) chk("result_data", result_bits_data, response_result_bits_data[head*W +: W]);
    if (e_rv != 0) begin
      chk("req_A", request_operands_bits_A, operands_bits_A);
      chk("req_B", request_operands_bits_B, operands_bits_B);
    end
    m_push = operands_val && e_ordy;
    m_g    = g;
    m_pop  = e_resv && result_rdy;
    if (request_val != 0) glog.push_back($clog2(request_val));
    if (result_val && result_rdy) rlog.push_back(result_bits_data);
  end

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mP = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin mq.push_back(m_g); mP = (m_g + 1) % N; end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    response_result_bits_data[i*W +: W] = v;
  endtask

  initial begin
    reset = 1; operands_val = 1; operands_bits_A = 32'd48; operands_bits_B = 32'd18;
    request_rdy = 4'hF; response_val = 4'hF; result_rdy = 1;
    for (int i = 0; i < N; i++) set_data(i, W'(100 + i));
    cyc(2);
    reset = 0; operands_val = 0; response_val = 0; result_rdy = 0;
    #1 chk("lit_reset_cnt", inflight_count, 0);

    // Four back-to-back dispatches with every unit ready.
    glog.delete();
    operands_val = 1;
    for (int i = 0; i < 4; i++) begin operands_bits_A = W'(10 + i); cyc(); end
    operands_val = 0;
    #1 chk("lit_cnt4", inflight_count, 4);
    chk("lit_glog_n", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk("lit_grant_seq", glog[i], i);
    rlog.delete();
    response_val = 4'hF; result_rdy = 1;
    cyc(4);
    response_val = 0; result_rdy = 0;
    #1 chk("lit_drain_cnt", inflight_count, 0);
    for (int i = 0; i < 4; i++) chk("lit_drain_data", rlog[i], 100 + i);

    // Pointer wrap with partial readiness.
    glog.delete();
    operands_val = 1; request_rdy = 4'hF; cyc(2);
    request_rdy = 4'b1011; cyc();
    request_rdy = 4'b0011; cyc();
    operands_val = 0; request_rdy = 4'hF;
    chk("lit_wrap_g2", glog[2], 3);
    chk("lit_wrap_g3", glog[3], 0);
    rlog.delete();
    response_val = 4'hF; result_rdy = 1; cyc(4);
    response_val = 0; result_rdy = 0;
    chk("lit_wrap_r2", rlog[2], 103);
    chk("lit_wrap_r3", rlog[3], 100);

    // Out-of-order completion must still return in dispatch order.
    reset = 1; cyc(); reset = 0;
    glog.delete(); rlog.delete();
    operands_val = 1; cyc(2); operands_val = 0;
    chk("lit_ooo_g1", glog[1], 1);
    set_data(1, 32'd7); set_data(0, 32'd3);
    response_val = 4'b0010; result_rdy = 1;
    #1 chk("lit_ooo_hold_rr", response_rdy, 0);
    chk("lit_ooo_hold_rv", result_val, 0);
    cyc(3);
    response_val = 4'b0011; cyc();
    response_val = 4'b0010; cyc();
    response_val = 0; result_rdy = 0;
    chk("lit_ooo_n", rlog.size(), 2);
    chk("lit_ooo_r0", rlog[0], 3);
    chk("lit_ooo_r1", rlog[1], 7);

    // Fill to D, then pop while still offering operands.
    for (int i = 0; i < N; i++) set_data(i, W'(200 + i));
    operands_val = 1; cyc(8);
    #1 chk("lit_full_cnt", inflight_count, 8);
    chk("lit_full_ordy", operands_rdy, 0);
    cyc();
    rlog.delete();
    response_val = 4'b0100; result_rdy = 1;
    #1 chk("lit_full_pop_ordy", operands_rdy, 0);
    chk("lit_full_pop_rv", result_val, 1);
    cyc();
    operands_val = 0; response_val = 0; result_rdy = 0;
    #1 chk("lit_full_after", inflight_count, 7);
    chk("lit_full_data", rlog[0], 202);

    // Back-pressure from the output FIFO.
    response_val = 4'hF;
    #1 chk("lit_bp_rv", result_val, 1);
    chk("lit_bp_rr", response_rdy, 0);
    cyc();
    chk("lit_bp_cnt", inflight_count, 7);
    result_rdy = 1; cyc(2); result_rdy = 0;
    #1 chk("lit_bp_cnt5", inflight_count, 5);

    // Reset mid-operation discards everything.
    reset = 1; cyc(); reset = 0;
    #1 chk("lit_rst_cnt", inflight_count, 0);
    chk("lit_rst_rv", result_val, 0);
    glog.delete();
    operands_val = 1; cyc(); operands_val = 0; response_val = 0;
    chk("lit_rst_p0", glog[0], 0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gcd_rr_arbiter.md
GCD_RR_ARBITER -- requirements
Module: gcd_rr_arbiter

Interface
REQ-001 Parameter W, default 32: operand and result width in bits, W>=1.
REQ-002 Parameter N, default 4: number of attached GCD units, N>=2.
REQ-003 Parameter D, default 8: ordering-queue depth (max in-flight operations), power of two, D>=2.
REQ-004 Derived: U=$clog2(N) tag width; C=$clog2(D+1) count width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 operands_val  in  1  input FIFO holds an operand pair.
REQ-008 operands_bits_A / operands_bits_B  in  W each  operand pair.
REQ-009 operands_rdy  out  1  arbiter accepts the pair this cycle.
REQ-010 request_val  out  N  per-unit request valid, one-hot or zero.
REQ-011 request_operands_bits_A / request_operands_bits_B  out  W each  operands broadcast to all units.
REQ-012 request_rdy  in  N  per-unit ready to accept a request.
REQ-013 response_val  in  N  per-unit result valid.
REQ-014 response_result_bits_data  in  N*W  unit i result at bits [i*W +: W].
REQ-015 response_rdy  out  N  per-unit result consumed, one-hot or zero.
REQ-016 result_val  out  1  ordered result valid to output FIFO.
REQ-017 result_bits_data  out  W  ordered result.
REQ-018 result_rdy  in  1  output FIFO ready.
REQ-019 inflight_count  out  C  operations dispatched and not yet returned.

Function
REQ-020 Dispatch uses round-robin: pointer P (U bits) names the highest-priority unit; the grant g is the first unit with request_rdy=1 scanning P, P+1, ..., N-1, 0, ..., P-1.
REQ-021 operands_rdy = (any request_rdy) AND (inflight_count < D) AND NOT reset.
REQ-022 request_val[g] = operands_val AND operands_rdy; all other request_val bits are 0.
REQ-023 Dispatch fire = operands_val AND operands_rdy; on fire, tag g is pushed into the ordering queue and P <= (g+1) mod N; without a fire, P holds.
REQ-024 Request operands are passed through combinationally; dispatch adds zero cycles of latency.
REQ-025 The ordering queue is a D-entry circular buffer of U-bit tags with wrapping read/write pointers; the head tag H is the oldest un-returned dispatch.
REQ-026 result_val = (queue non-empty) AND response_val[H] AND NOT reset; result_bits_data = unit H's result slice (don't-care when result_val=0).
REQ-027 response_rdy[H] = (queue non-empty) AND response_val[H] AND result_rdy; all other bits are 0; a unit not at the head is never drained, even if valid.
REQ-028 Result fire = result_val AND result_rdy; on fire the head tag pops.
REQ-029 inflight_count: +1 on dispatch fire only, -1 on result fire only, unchanged on both or neither.
REQ-030 Full (count=D): operands_rdy=0 even when a pop happens in the same cycle; there is no bypass.
REQ-031 Empty (count=0): result_val=0 and response_rdy=0 regardless of response_val; there is no bypass.
REQ-032 A simultaneous dispatch and result fire with 0<count<D is legal; push and pop both occur.
REQ-033 Results leave in dispatch order, independent of unit completion order.

Reset
REQ-034 While reset=1: operands_rdy, request_val, response_rdy and result_val are 0.
REQ-035 Reset sets P=0, empties the ordering queue, and sets inflight_count=0; reset mid-operation discards all in-flight tags.

Verification
REQ-036 After reset, N=4, all request_rdy=1, operands_val held for 4 cycles -> grants go to units 0,1,2,3 in order; inflight_count=4.
REQ-037 P=2 with request_rdy=4'b1011 -> grant to unit 3, then P=0; with request_rdy=4'b0011 -> grant to unit 0.
REQ-038 Dispatch to units 0 then 1; unit 1 responds first (val 7), unit 0 later (val 3) -> result_bits_data is 3 then 7; response_rdy[1] stays 0 until unit 0 pops.
REQ-039 D=8 with 8 dispatches and no returns -> operands_rdy=0 and inflight_count=8; when one result fires in the same cycle operands_val=1, there is no dispatch that cycle and count=7 after it.
REQ-040 result_rdy=0 with the head response valid -> result_val=1, response_rdy all 0, count unchanged; raise result_rdy -> one pop per cycle.
REQ-041 reset asserted with count=5 -> next cycle count=0, P=0, result_val=0 even if response_val is high.
